chimera_spi_target: RTL
=======================

Name: chimera_spi_target

Overview:
- Synthesizable single-lane SPI target: the responder end of the SoC SPI host link (mode 0, CPOL=0/CPHA=0, MSB first).
- Oversamples host SCK/CSB/MOSI on the local clock and deserializes received bytes into an RX FIFO.
- Serializes TX bytes from a valid/ready stream onto MISO.
- Used as an on-chip test target for the SPI host and as a bench responder in place of a behavioural flash model.

Parameters:
- RxDepth, 4: RX FIFO entries; power of two, ≥2.
- FillByte, 8'hFF: byte driven on MISO when no TX byte is available at a byte boundary.
- CntWidth, 16: width of the received-byte counter.

Ports:
- clk_i  in  1  system clock; must run ≥4× SCK.
- rst_i  in  1  asynchronous active-high reset.
- spi_sck_i  in  1  host serial clock (asynchronous).
- spi_csb_i  in  1  host chip select, active low (asynchronous).
- spi_sd_i  in  1  MOSI (asynchronous).
- spi_sd_o  out  1  MISO data.
- spi_sd_en_o  out  1  MISO output enable.
- rx_data_o  out  8  head of RX FIFO.
- rx_valid_o  out  1  RX FIFO non-empty.
- rx_ready_i  in  1  pop RX FIFO when high together with rx_valid_o.
- tx_data_i  in  8  next byte to transmit.
- tx_valid_i  in  1  tx_data_i valid.
- tx_ready_o  out  1  single-cycle pulse; TX byte consumed.
- rx_overflow_o  out  1  sticky: a received byte was dropped.
- clear_i  in  1  synchronous clear of rx_overflow_o and byte_cnt_o.
- busy_o  out  1  transaction active (synced CSB low).
- byte_cnt_o  out  CntWidth  complete bytes received since reset or clear; wraps modulo 2^CntWidth.

Behaviour:
- Synchronization: SCK, CSB and MOSI each pass through a 2-flop synchronizer, then one delay flop for edge detection. An edge is acted on 3 clk_i cycles after the pin edge.
- Reset values: all outputs 0; rx_data_o is 0 and the FIFO is empty.
- FSM IDLE, CSB falling edge -> ACTIVE:
  - bit_cnt=0.
  - TX load: if tx_valid_i, the shift register takes tx_data_i and tx_ready_o pulses for one cycle; otherwise it takes FillByte.
  - spi_sd_en_o=1 and spi_sd_o = shift[7], both in the same cycle as the load.
- ACTIVE, SCK rising edge:
  - rx_shift = {rx_shift[6:0], synced MOSI}; bit_cnt increments mod 8.
  - When bit 8 completes, the assembled byte is pushed into the FIFO and byte_cnt_o increments, visible the cycle after the edge.
- ACTIVE, SCK falling edge:
  - After a completed byte (bit_cnt==0): load the next TX byte using the same load rule.
  - Otherwise: shift TX left by 1.
  - spi_sd_o always reflects shift[7].
- ACTIVE, CSB rising edge -> IDLE:
  - spi_sd_en_o=0, spi_sd_o=0, bit_cnt=0.
  - A partial RX byte is discarded and not counted.
  - A partially sent TX byte is lost and is not re-offered.
- CSB rise and SCK edge detected in the same cycle: CSB wins and the SCK edge is ignored.
- SCK edges while IDLE are ignored.
- RX FIFO:
  - rx_valid_o = non-empty; pop on rx_valid_o && rx_ready_i.
  - Push when full: byte dropped, rx_overflow_o set (next cycle), byte_cnt_o still increments.
  - Push and pop in the same cycle when full: the push is accepted.
- clear_i is lower priority than a same-cycle overflow set; on a same-cycle byte completion, byte_cnt_o becomes 1.
- Reset asserted mid-transaction: immediate return to IDLE with all reset values. The FSM re-arms only on a fresh CSB falling edge observed after reset deassertion.

Optional Feature:
- Macro: CHIMERA_SPI_TARGET_LOOPBACK_EN.
- With the macro defined: at a byte boundary with no tx_valid_i, the TX shift register loads the most recently completed RX byte instead of FillByte. At the first byte after CSB fall, FillByte is used. tx_valid_i data still has priority.
- Without the macro: FillByte only.

Test Plan:
- Reset, then CSB low with tx_data_i=8'hA5 valid, host sends 8'h3C: tx_ready_o pulses once; host reads 8'hA5; rx_data_o=8'h3C, rx_valid_o=1, byte_cnt_o=1.
- Host sends 3 bytes with tx_valid_i=0: host reads 8'hFF ×3 (8'hFF, 8'h(byte1), 8'h(byte2) with CHIMERA_SPI_TARGET_LOOPBACK_EN); FIFO holds the 3 bytes in order.
- rx_ready_i=0, host sends 5 bytes (RxDepth=4): first 4 retained, 5th dropped; rx_overflow_o=1; byte_cnt_o=5; clear_i -> overflow 0, count 0.
- CSB raised after 5 SCK cycles: no push, byte_cnt_o unchanged, spi_sd_en_o=0 within 3 cycles; next transaction receives a full byte correctly.
- FIFO full with a pop and the 8th-bit push in the same cycle: no overflow; FIFO stays full; order preserved.
- rst_i asserted mid-byte: all outputs 0 asynchronously; after release, SCK toggling with CSB held low produces no bytes until CSB is toggled high then low.

Source files
------------

// File: rtl/chimera_spi_target_if.sv
// Bus bundle for chimera_spi_target: SPI pins, RX/TX byte streams and status.
// slave = the target block, master = whatever drives the pins and streams.
interface chimera_spi_target_if #(
  parameter int CntWidth = 16
);
  logic                spi_sck_i;
  logic                spi_csb_i;
  logic                spi_sd_i;
  logic                spi_sd_o;
  logic                spi_sd_en_o;
  logic [7:0]          rx_data_o;
  logic                rx_valid_o;
  logic                rx_ready_i;
  logic [7:0]          tx_data_i;
  logic                tx_valid_i;
  logic                tx_ready_o;
  logic                rx_overflow_o;
  logic                clear_i;
  logic                busy_o;
  logic [CntWidth-1:0] byte_cnt_o;

  modport slave (
    input  spi_sck_i, spi_csb_i, spi_sd_i, rx_ready_i, tx_data_i, tx_valid_i, clear_i,
    output spi_sd_o, spi_sd_en_o, rx_data_o, rx_valid_o, tx_ready_o, rx_overflow_o,
           busy_o, byte_cnt_o
  );

  modport master (
    output spi_sck_i, spi_csb_i, spi_sd_i, rx_ready_i, tx_data_i, tx_valid_i, clear_i,
    input  spi_sd_o, spi_sd_en_o, rx_data_o, rx_valid_o, tx_ready_o, rx_overflow_o,
           busy_o, byte_cnt_o
  );
endinterface

// File: rtl/chimera_spi_target.sv
// SPI mode-0 target: oversampled pins, RX byte FIFO, TX byte stream onto MISO.
// Optional macro CHIMERA_SPI_TARGET_LOOPBACK_EN: idle byte boundaries echo the last RX byte.
module chimera_spi_target #(
  parameter int         RxDepth  = 4,
  parameter logic [7:0] FillByte = 8'hFF,
  parameter int         CntWidth = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  chimera_spi_target_if.slave bus
);
  localparam int PW = $clog2(RxDepth);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_sck_s, r_csb_s, r_sd_s;
  logic [2:0]  r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0]  r_rx_shift, w_rx_shift_nxt;
  logic [7:0]  r_tx_shift, w_tx_shift_nxt;
  logic [7:0]  w_rx_byte, w_fill;
  logic        w_sck_rise, w_sck_fall, w_csb_rise, w_csb_fall;
  logic        w_load, w_push, w_tx_take;

  logic [7:0]          r_mem [RxDepth];
  logic [PW:0]         r_wptr, r_rptr;
  logic                w_full, w_empty, w_pop, w_push_ok, w_ovf_set;
  logic                r_ovf;
  logic [CntWidth-1:0] r_cnt;

`ifdef CHIMERA_SPI_TARGET_LOOPBACK_EN
  logic [7:0] r_last_rx;
`endif

  // Stages [1:0] synchronize, stage [2] is the edge-detect delay.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sck_s <= '0;
      r_csb_s <= '0;
      r_sd_s  <= '0;
    end else begin
      r_sck_s <= {r_sck_s[1:0], bus.spi_sck_i};
      r_csb_s <= {r_csb_s[1:0], bus.spi_csb_i};
      r_sd_s  <= {r_sd_s[1:0],  bus.spi_sd_i};
    end
  end

  assign w_sck_rise =  r_sck_s[1] & ~r_sck_s[2];
  assign w_sck_fall = ~r_sck_s[1] &  r_sck_s[2];
  assign w_csb_rise =  r_csb_s[1] & ~r_csb_s[2];
  assign w_csb_fall = ~r_csb_s[1] &  r_csb_s[2];
  assign w_rx_byte  = {r_rx_shift[6:0], r_sd_s[2]};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_bit_cnt  <= '0;
      r_rx_shift <= '0;
      r_tx_shift <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_rx_shift <= w_rx_shift_nxt;
      r_tx_shift <= w_tx_shift_nxt;
    end
  end

  // CSB edges take priority over any SCK edge seen in the same cycle.
  always_comb begin
    w_state_nxt    = r_state;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_rx_shift_nxt = r_rx_shift;
    w_tx_shift_nxt = r_tx_shift;
    w_load         = 1'b0;
    w_push         = 1'b0;
    w_fill         = FillByte;
    case (r_state)
      IDLE: begin
        if (w_csb_fall) begin
          w_state_nxt   = ACTIVE;
          w_bit_cnt_nxt = 3'd0;
          w_load        = 1'b1;
        end
      end
      ACTIVE: begin
        if (w_csb_rise) begin
          w_state_nxt    = IDLE;
          w_bit_cnt_nxt  = 3'd0;
          w_rx_shift_nxt = 8'h00;
        end else if (w_sck_rise) begin
          w_rx_shift_nxt = w_rx_byte;
          w_bit_cnt_nxt  = r_bit_cnt + 3'd1;
          w_push         = (r_bit_cnt == 3'd7);
        end else if (w_sck_fall) begin
          if (r_bit_cnt == 3'd0) begin
            w_load = 1'b1;
`ifdef CHIMERA_SPI_TARGET_LOOPBACK_EN
            w_fill = r_last_rx;
`endif
          end else begin
            w_tx_shift_nxt = {r_tx_shift[6:0], 1'b0};
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    w_tx_take = w_load & bus.tx_valid_i;
    if (w_load) w_tx_shift_nxt = bus.tx_valid_i ? bus.tx_data_i : w_fill;
  end

`ifdef CHIMERA_SPI_TARGET_LOOPBACK_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)       r_last_rx <= 8'h00;
    else if (w_push) r_last_rx <= w_rx_byte;
  end
`endif

  // RX FIFO: extra pointer bit separates full from empty.
  assign w_empty   = (r_wptr == r_rptr);
  assign w_full    = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
  assign w_pop     = ~w_empty & bus.rx_ready_i;
  assign w_push_ok = w_push & (~w_full | w_pop);
  assign w_ovf_set = w_push & w_full & ~w_pop;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < RxDepth; i++) r_mem[i] <= 8'h00;
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wptr[PW-1:0]] <= w_rx_byte;
        r_wptr                <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
    end
  end

  // Overflow set beats clear; a clear alongside a completed byte leaves count 1.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ovf <= 1'b0;
      r_cnt <= '0;
    end else begin
      if (w_ovf_set)        r_ovf <= 1'b1;
      else if (bus.clear_i) r_ovf <= 1'b0;
      if (bus.clear_i)      r_cnt <= CntWidth'(w_push);
      else if (w_push)      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bus.spi_sd_en_o   = (r_state == ACTIVE);
  assign bus.spi_sd_o      = (r_state == ACTIVE) & r_tx_shift[7];
  assign bus.busy_o        = (r_state == ACTIVE);
  assign bus.tx_ready_o    = w_tx_take;
  assign bus.rx_data_o     = r_mem[r_rptr[PW-1:0]];
  assign bus.rx_valid_o    = ~w_empty;
  assign bus.rx_overflow_o = r_ovf;
  assign bus.byte_cnt_o    = r_cnt;
endmodule
